genie_mem_responder: RTL and testbench

// - Memory-side responder for the accelerator data port (wvalid/wready/waddr/wdata, rvalid/rready/raddr/rdata).
// - Serves one request at a time from a single-port word array with fixed latency.
// - Acknowledges each request with a one-cycle ready pulse; read data is valid in the pulse cycle.
// - Sits opposite the top-level accelerator; used as the on-chip data store for layer loaders and as the bench memory model.

---
 rtl/genie_mem_responder.sv | 136 +++++++++++++
 tb/tb_genie_mem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/genie_mem_responder.sv
// Single-port word memory responder: one request at a time, one-cycle wready/rready ack pulse.
// Latency: accept at T, pulse at T+WR_LAT / T+RD_LAT (plus 0-3 LFSR stall cycles with GENIE_MEM_STALL_EN).
// Backpressure: initiator holds valid until the pulse; no accept in a pulse cycle, so min period is LAT+1.
module genie_mem_responder #(
   parameter int DEPTH_LOG2 = 16,
   parameter int RD_LAT     = 2,
   parameter int WR_LAT     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wvalid,
   output logic        wready,
   input  logic [25:0] waddr,
   input  logic [31:0] wdata,
   input  logic        rvalid,
   output logic        rready,
   input  logic [25:0] raddr,
   output logic [31:0] rdata,
   output logic        busy
);

   localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 4);

   typedef enum logic [1:0] {IDLE, WR, RD} state_t;
   typedef enum logic {GRANT_WR, GRANT_RD} grant_t;

   state_t                state, state_nxt;
   grant_t                last_grant, last_grant_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [DEPTH_LOG2-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [31:0]           rdata_q;
   logic                  accept;
   logic                  grant_rd;
   logic [1:0]            extra;
   logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];

   // Upper address bits are deliberately dropped so out-of-range addresses wrap.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{waddr[25:DEPTH_LOG2], raddr[25:DEPTH_LOG2]};

`ifdef GENIE_MEM_STALL_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= 8'hA5;
      end else if (accept) begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign extra = lfsr[1:0];
`else
   assign extra = 2'd0;
`endif

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      last_grant_nxt = last_grant;
      accept         = 1'b0;
      grant_rd       = 1'b0;
      wready         = 1'b0;
      rready         = 1'b0;
      unique case (state)
         IDLE: begin
            if (wvalid || rvalid) begin
               accept         = 1'b1;
               grant_rd       = rvalid && (!wvalid || last_grant == GRANT_WR);
               last_grant_nxt = grant_rd ? GRANT_RD : GRANT_WR;
               state_nxt      = grant_rd ? RD : WR;
               cnt_nxt        = (grant_rd ? CNT_W'(RD_LAT - 1) : CNT_W'(WR_LAT - 1))
                                + CNT_W'(extra);
            end
         end
         WR: begin
            if (cnt == '0) begin
               wready    = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         RD: begin
            if (cnt == '0) begin
               rready    = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A transaction caught by reset must not pulse or commit.
      if (rst) begin
         accept = 1'b0;
         wready = 1'b0;
         rready = 1'b0;
      end
   end

   assign busy  = accept || (!rst && state != IDLE);
   assign rdata = rready ? mem[addr_q] : rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= GRANT_RD;
         rdata_q    <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         last_grant <= last_grant_nxt;
         if (rready) begin
            rdata_q <= mem[addr_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= grant_rd ? raddr[DEPTH_LOG2-1:0] : waddr[DEPTH_LOG2-1:0];
         wdata_q <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (wready) begin
         mem[addr_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_genie_mem_responder.sv
// Scoreboard bench for genie_mem_responder: expected pulses queued at request time, checked on pulse.
// Build with GENIE_MEM_STALL_EN defined to check LFSR-driven latency as well.
module tb_genie_mem_responder;

   localparam int DEPTH_LOG2 = 16;
   localparam int RD_LAT     = 2;
   localparam int WR_LAT     = 1;
   localparam int DEPTH      = 1 << DEPTH_LOG2;

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wvalid, rvalid;
   logic        wready, rready, busy;
   logic [25:0] waddr, raddr;
   logic [31:0] wdata, rdata;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   exp_t        exp_q [$];
   exp_t        mon_e;
   logic [31:0] model [int];
   logic [7:0]  tb_lfsr = 8'hA5;

   genie_mem_responder #(
      .DEPTH_LOG2(DEPTH_LOG2),
      .RD_LAT    (RD_LAT),
      .WR_LAT    (WR_LAT)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .wvalid(wvalid),
      .wready(wready),
      .waddr (waddr),
      .wdata (wdata),
      .rvalid(rvalid),
      .rready(rready),
      .raddr (raddr),
      .rdata (rdata),
      .busy  (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Latency of the next accepted request; the stall LFSR advances once per accept.
   function automatic int next_lat(input int base);
      int l = base;
`ifdef GENIE_MEM_STALL_EN
      l += int'(tb_lfsr[1:0]);
      tb_lfsr = {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
`endif
      return l;
   endfunction

   always @(negedge clk) begin
      if (wready || rready) begin
         chk("no_coincide", 32'(wready & rready), 0);
         chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("pulse_type", 32'(rready), 32'(mon_e.is_rd));
            chk("pulse_cyc", cyc, mon_e.cyc);
            if (mon_e.is_rd) chk("rdata", rdata, mon_e.data);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; wvalid = 1'b0; rvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_wready", 32'(wready), 0);
      chk("rst_rready", 32'(rready), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      tb_lfsr = 8'hA5;
      @(negedge clk);
      #1;
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_rdata", rdata, 0);
   endtask

   task automatic do_write(input logic [25:0] a, input logic [31:0] d);
      exp_t e;
      bit   got = 0;
      @(negedge clk);
      #1;
      chk("wr_idle_busy", 32'(busy), 0);
      wvalid = 1'b1; waddr = a; wdata = d;
      e.is_rd = 1'b0; e.data = d; e.cyc = cyc + next_lat(WR_LAT);
      exp_q.push_back(e);
      model[int'(a) & (DEPTH - 1)] = d;
      #1;
      chk("wr_acc_busy", 32'(busy), 1);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         #1;
         if (wready) begin
            got = 1;
            chk("wr_pulse_busy", 32'(busy), 1);
         end
      end
      chk("wr_done", 32'(got), 1);
      wvalid = 1'b0;
   endtask

   task automatic do_read(input logic [25:0] a);
      exp_t e;
      bit   got = 0;
      int   t0, lat;
      @(negedge clk);
      #1;
      chk("rd_idle_busy", 32'(busy), 0);
      rvalid = 1'b1; raddr = a;
      t0 = cyc;
      lat = 0;
      e.is_rd = 1'b1; e.data = model[int'(a) & (DEPTH - 1)]; e.cyc = t0 + next_lat(RD_LAT);
      exp_q.push_back(e);
      #1;
      chk("rd_acc_busy", 32'(busy), 1);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         #1;
         if (rready) begin
            got = 1;
            lat = cyc - t0;
            chk("rd_pulse_busy", 32'(busy), 1);
         end
      end
      chk("rd_done", 32'(got), 1);
      chk("rd_lat_range", 32'(lat >= RD_LAT && lat <= RD_LAT + 3), 1);
      rvalid = 1'b0;
   endtask

   initial begin
      int   t;
      bit   drained;
      exp_t e;
      rst = 1'b1; wvalid = 1'b0; rvalid = 1'b0;
      waddr = '0; raddr = '0; wdata = '0;

      do_reset();

      do_write(26'h10, 32'hDEADBEEF);
      do_read(26'h10);
      repeat (3) @(negedge clk);
      chk("rdata_hold", rdata, 32'hDEADBEEF);
      do_write(26'h11, 32'h0BADF00D);
      chk("rdata_hold_wr", rdata, 32'hDEADBEEF);

      do_write(26'h0000005, 32'h12345678);
      do_read(26'h0010005);

      for (int i = 0; i < 4; i++) do_write(26'h100 + 26'(i), $urandom);
      for (int i = 3; i >= 0; i--) do_read(26'h100 + 26'(i));

      // Both requests held from reset: grants must alternate W,R,W,R.
      do_reset();
      @(negedge clk);
      #1;
      wvalid = 1'b1; rvalid = 1'b1;
      waddr = 26'h20; raddr = 26'h20; wdata = 32'hA0A0A0A0;
      model[32'h20] = 32'hA0A0A0A0;
      t = cyc;
      for (int k = 0; k < 4; k++) begin
         e.is_rd = k[0];
         e.data  = 32'hA0A0A0A0;
         e.cyc   = t + next_lat(k[0] ? RD_LAT : WR_LAT);
         t       = e.cyc + 1;
         exp_q.push_back(e);
      end
      drained = 0;
      for (int i = 0; i < 100 && !drained; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) drained = 1;
      end
      chk("arb_drained", 32'(drained), 1);
      wvalid = 1'b0; rvalid = 1'b0;
      exp_q.delete();

      // Reset in the middle of a read: no pulse, data in the array survives.
      do_write(26'h40, 32'hCAFEF00D);
      @(negedge clk);
      #1;
      rvalid = 1'b1; raddr = 26'h40;
      void'(next_lat(RD_LAT));
      @(negedge clk);
      #1;
      rst = 1'b1; rvalid = 1'b0;
      @(negedge clk);
      #1;
      chk("abort_rready", 32'(rready), 0);
      chk("abort_busy", 32'(busy), 0);
      rst = 1'b0;
      tb_lfsr = 8'hA5;
      @(negedge clk);
      #1;
      chk("abort_busy_after", 32'(busy), 0);
      chk("abort_rready_after", 32'(rready), 0);
      do_read(26'h40);

      for (int i = 0; i < 64; i++) do_read(26'h100 + 26'(i % 4));

      repeat (4) @(negedge clk);
      chk("sb_empty_end", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
